led_seq_ctrl: RTL
=================

Name: led_seq_ctrl

Overview:
- Bus-side controller sitting between the CPU store path and the memory-mapped LED register at 0x060.
- Passes CPU writes through unchanged.
- Owns three control registers and autonomously issues timed LED-register writes for rotate and blink patterns.
- Shares the single LED write port between the CPU and its pattern engine; the CPU always has priority.

Parameters:
- LED_ADDR, 12'h060, address of the LED data register (downstream target)
- CTRL_ADDR, 12'h064, control register: bit0 enable, bits[2:1] mode (00 rotl, 01 rotr, 10 blink, 11 hold)
- PERIOD_ADDR, 12'h068, step period in clk cycles (32-bit)
- PAT_ADDR, 12'h06C, pattern seed register (bits[23:0])
- DEFAULT_PERIOD, 32'd50_000_000, period register reset value

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_addr  in  12  CPU bus address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  32  CPU write data
- led_addr  out  12  address toward LED peripheral
- led_we  out  1  write strobe toward LED peripheral
- led_wdata  out  32  write data toward LED peripheral
- busy  out  1  high while the engine is enabled (state != IDLE)

Behaviour:
- One clock (clk). rst is synchronous and active-high; all state is sampled on posedge clk.
- Reset values:
  - state=IDLE, ctrl=0, period=DEFAULT_PERIOD
  - pat=24'h000001, cnt=0, blink_phase=0, busy=0
- Register writes (cpu_we=1) take effect on the next edge:
  - CTRL_ADDR loads wdata[2:0].
  - PERIOD_ADDR loads wdata.
  - PAT_ADDR loads wdata[23:0] and clears blink_phase.
  - LED_ADDR also reloads pat with wdata[23:0], so the CPU override becomes the new sequence seed.
- Output mux is combinational, zero latency:
  - cpu_we=1: led_addr/we/wdata = cpu_addr/1/cpu_wdata.
  - Else if state=ISSUE: led_addr=LED_ADDR, led_we=1, led_wdata={8'h0, pat_out}.
  - Else: led_addr=cpu_addr, led_we=0, led_wdata=cpu_wdata.
- FSM states are IDLE, COUNT, ISSUE.
  - IDLE: cnt=0. Enters COUNT when ctrl.enable=1.
  - COUNT: cnt increments. When cnt >= eff_period-1, cnt clears, pat advances per mode, and the state moves to ISSUE. eff_period = (period==0) ? 1 : period.
  - ISSUE: if cpu_we=0, the write is issued this cycle and the state moves to COUNT. If cpu_we=1, the state holds in ISSUE (stall) with pat unchanged; the write retries every cycle until the bus is free.
- Pattern advance:
  - rotl: pat = {pat[22:0], pat[23]}
  - rotr: pat = {pat[0], pat[23:1]}
  - blink: blink_phase toggles; pat_out = blink_phase ? 24'h0 : pat
  - hold: pat unchanged (the periodic refresh write still occurs)
  - In non-blink modes, pat_out = pat.
- Enable cleared in any state: next state is IDLE and any pending ISSUE is dropped. The LED keeps its last value.
- Simultaneous events:
  - A CPU write to PAT_ADDR in the same cycle as an advance: the CPU value wins and the advance is discarded.
  - A CPU write to PERIOD_ADDR mid-count: the new period applies to the comparison from the next cycle. If cnt already exceeds the new limit, the step fires next cycle.
- rst asserted mid-ISSUE: no engine write is issued after the reset edge.

Optional Feature:
- Macro: LED_SEQ_READBACK_EN.
- Defined: adds port cpu_rdata out 32, combinational.
  - CTRL_ADDR reads {29'h0, ctrl}.
  - PERIOD_ADDR reads period.
  - PAT_ADDR reads {8'h0, pat}.
  - LED_ADDR reads {8'h0, last value written downstream}; this needs a 24-bit shadow register, reset to 0.
  - Other addresses read 0.
- Undefined: no cpu_rdata port and no shadow register; registers are write-only.

Decomposition:
- Shared package (led_seq_pkg):
  - address constants LED_ADDR/CTRL_ADDR/PERIOD_ADDR/PAT_ADDR
  - mode encodings MODE_ROTL/ROTR/BLINK/HOLD
  - FSM state encoding ST_IDLE/COUNT/ISSUE
- One sub-module: led_seq_prescaler (cnt, eff_period clamp, tick output, clear-on-disable). The FSM, register file and arbitration mux stay in the top.

Test Plan:
- Reset default: assert rst 2 cycles -> busy=0, led_we=cpu_we, and the first enable produces pat_out=24'h000001.
- Rotate-left: PERIOD=4, PAT=24'h800001, CTRL=3'b001 -> led_we pulses every 5 cycles (4 count + 1 issue) with wdata 0x000003, then 0x000006, then 0x00000C.
- Blink with period 0: PERIOD=0, PAT=24'hFFFFFF, CTRL=3'b101 -> writes alternate 0x000000 and 0xFFFFFF, with period treated as 1.
- Arbitration stall: in ISSUE, hold cpu_we=1 at addr 0x100 for 3 cycles -> led_addr=0x100 for those 3 cycles, then the engine write to 0x060 is issued in the 4th cycle with an unchanged pattern.
- CPU override: with rotr enabled, write 0x060 with 0x000010 -> passes through the same cycle, and the next engine write is 0x000008.
- Disable mid-count: clear enable while in ISSUE under CPU stall -> IDLE next cycle, no engine write follows, busy=0. With LED_SEQ_READBACK_EN defined, reading 0x060 returns the last written value.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants, encodings and pattern helper for the LED sequence controller.
// Optional readback (macro LED_SEQ_READBACK_EN) is implemented in led_seq_ctrl.
package led_seq_pkg;

  localparam logic [11:0] LED_ADDR       = 12'h060;
  localparam logic [11:0] CTRL_ADDR      = 12'h064;
  localparam logic [11:0] PERIOD_ADDR    = 12'h068;
  localparam logic [11:0] PAT_ADDR       = 12'h06C;
  localparam logic [31:0] DEFAULT_PERIOD = 32'd50_000_000;
  localparam logic [23:0] PAT_RESET      = 24'h000001;

  typedef enum logic [1:0] {
    MODE_ROTL  = 2'b00,
    MODE_ROTR  = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Bit 0 is enable, bits [2:1] select the mode.
  typedef struct packed {
    mode_e mode;
    logic  enable;
  } ctrl_t;

  function automatic logic [23:0] rotate_pat(input mode_e mode, input logic [23:0] pat);
    logic [23:0] res;
    res = pat;
    case (mode)
      MODE_ROTL: res = {pat[22:0], pat[23]};
      MODE_ROTR: res = {pat[0], pat[23:1]};
      default:   res = pat;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period counter: counts while running, fires tick at the end of the period,
// treats a zero period as one cycle and clears whenever the engine is disabled.
module led_seq_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        run_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] eff_period;

  always_comb begin
    eff_period = (period_i == 32'd0) ? 32'd1 : period_i;
    // >= rather than == so a shortened period mid-count fires immediately.
    tick_o     = enable_i && run_i && (cnt_q >= eff_period - 32'd1);
    cnt_d      = cnt_q + 32'd1;
    if (!enable_i || !run_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: CPU pass-through plus a rotate/blink pattern engine
// sharing the LED write port. Define LED_SEQ_READBACK_EN to add cpu_rdata.
module led_seq_ctrl
  import led_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [11:0] led_addr,
  output logic        led_we,
  output logic [31:0] led_wdata,
  output logic        busy
`ifdef LED_SEQ_READBACK_EN
  ,
  output logic [31:0] cpu_rdata
`endif
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] period_q, period_d;
  logic [23:0] pat_q, pat_d;
  logic        phase_q, phase_d;
  logic        busy_q;
  logic        tick;
  logic [23:0] pat_out;

  logic wr_led, wr_ctrl, wr_period, wr_pat;
  assign wr_led    = cpu_we && (cpu_addr == LED_ADDR);
  assign wr_ctrl   = cpu_we && (cpu_addr == CTRL_ADDR);
  assign wr_period = cpu_we && (cpu_addr == PERIOD_ADDR);
  assign wr_pat    = cpu_we && (cpu_addr == PAT_ADDR);

  // Enable decisions see this cycle's CTRL write so a disable lands on the same edge.
  assign ctrl_d  = wr_ctrl ? ctrl_t'(cpu_wdata[2:0]) : ctrl_q;
  assign pat_out = (ctrl_q.mode == MODE_BLINK && phase_q) ? 24'h0 : pat_q;

  led_seq_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable_i (ctrl_d.enable),
    .run_i    (state_q == ST_COUNT),
    .period_i (period_q),
    .tick_o   (tick)
  );

  always_comb begin
    period_d = wr_period ? cpu_wdata : period_q;
    pat_d    = pat_q;
    phase_d  = phase_q;
    state_d  = state_q;

    // A CPU pattern or LED write overrides any advance in the same cycle.
    if (wr_pat || wr_led) begin
      pat_d = cpu_wdata[23:0];
    end else if (tick) begin
      pat_d = rotate_pat(ctrl_q.mode, pat_q);
    end

    if (wr_pat) begin
      phase_d = 1'b0;
    end else if (tick && !wr_led && ctrl_q.mode == MODE_BLINK) begin
      phase_d = ~phase_q;
    end

    if (!ctrl_d.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_COUNT;
        ST_COUNT: state_d = tick ? ST_ISSUE : ST_COUNT;
        ST_ISSUE: state_d = cpu_we ? ST_ISSUE : ST_COUNT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      period_q <= DEFAULT_PERIOD;
      pat_q    <= PAT_RESET;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      pat_q    <= pat_d;
      phase_q  <= phase_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // CPU always wins the port; the engine retries from ISSUE until the bus is free.
  always_comb begin
    led_addr  = cpu_addr;
    led_we    = 1'b0;
    led_wdata = cpu_wdata;
    if (cpu_we) begin
      led_we = 1'b1;
    end else if (state_q == ST_ISSUE) begin
      led_addr  = LED_ADDR;
      led_we    = 1'b1;
      led_wdata = {8'h0, pat_out};
    end
  end

  assign busy = busy_q;

`ifdef LED_SEQ_READBACK_EN
  logic [23:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (led_we && led_addr == LED_ADDR) begin
      shadow_q <= led_wdata[23:0];
    end
  end

  always_comb begin
    case (cpu_addr)
      LED_ADDR:    cpu_rdata = {8'h0, shadow_q};
      CTRL_ADDR:   cpu_rdata = {29'h0, ctrl_q};
      PERIOD_ADDR: cpu_rdata = period_q;
      PAT_ADDR:    cpu_rdata = {8'h0, pat_q};
      default:     cpu_rdata = 32'h0;
    endcase
  end
`endif

endmodule
